// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch/decode front end.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // Contents of the IF/ID pipeline register handed to decode
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
    } ifid_payload_t;

    // Instruction addresses are always word aligned
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_ifid_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble.
module ifid_reg
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                stall,
    input  logic                load,
    input  logic [ADDR_W-1:0]   load_pc,
    input  logic [INSTR_W-1:0]  load_instr,
    output logic                valid,
    output ifid_payload_t       payload
);

    // Valid bit and payload update with flush/stall/load priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                valid         <= 1'b1;
                payload.pc    <= load_pc;
                payload.pc4   <= load_pc + ADDR_W'(PC_STEP);
                payload.instr <= load_instr;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, kill flag,
// skid buffer for stalled responses, and the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds fetched/discarded response counters.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               redirect_valid_i,
    input  logic [INSTR_W-1:0] redirect_pc_i,
    output logic               imem_req_o,
    output logic [INSTR_W-1:0] imem_addr_o,
    input  logic               imem_ready_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               ifid_valid_o,
    output logic [INSTR_W-1:0] ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [15:0]        ifid_imm16_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_discard_o
`endif
);

    import mips_pkg::fetch_state_t;
    import mips_pkg::S_REQ;
    import mips_pkg::S_WAIT;
    import mips_pkg::S_HOLD;
    import mips_pkg::PC_STEP;
    import mips_pkg::ifid_payload_t;
    import mips_pkg::word_align;

    fetch_state_t       state;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               kill;
    logic               req_q;

    logic               load_c;
    logic               discard_c;
    logic [INSTR_W-1:0] load_pc_c;
    logic [INSTR_W-1:0] load_instr_c;
    logic [INSTR_W-1:0] pc_next_c;
    logic [INSTR_W-1:0] redirect_target_c;

    ifid_payload_t      payload;

    assign pc_next_c         = pc + INSTR_W'(PC_STEP);
    assign redirect_target_c = word_align(redirect_pc_i);

    // Decode which response (live or skid) loads IF/ID and which is discarded
    always_comb begin
        load_c       = 1'b0;
        discard_c    = 1'b0;
        load_pc_c    = pc;
        load_instr_c = imem_rdata_i;
        case (state)
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill || redirect_valid_i) begin
                        discard_c = 1'b1;
                    end else if (!stall_i) begin
                        load_c = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!redirect_valid_i && !stall_i) begin
                    load_c       = 1'b1;
                    load_pc_c    = skid_pc;
                    load_instr_c = skid_instr;
                end
            end
            default: ;
        endcase
    end

    // Fetch FSM, PC, kill flag, skid buffer and registered request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= word_align(RESET_PC);
            kill       <= 1'b0;
            req_q      <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (req_q && imem_ready_i) begin
                        // A redirect in the acceptance cycle orphans this request
                        state <= S_WAIT;
                        req_q <= 1'b0;
                        kill  <= redirect_valid_i;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill || redirect_valid_i) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end else if (!stall_i) begin
                            pc    <= pc_next_c;
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end else begin
                            skid_pc    <= pc;
                            skid_instr <= imem_rdata_i;
                            state      <= S_HOLD;
                        end
                    end else if (redirect_valid_i) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid_i) begin
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end else if (!stall_i) begin
                        pc    <= pc_next_c;
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_REQ;
                    req_q <= 1'b0;
                end
            endcase
            if (redirect_valid_i) begin
                pc <= redirect_target_c;
            end
        end
    end

    ifid_reg u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_i),
        .stall      (stall_i),
        .load       (load_c),
        .load_pc    (load_pc_c),
        .load_instr (load_instr_c),
        .valid      (ifid_valid_o),
        .payload    (payload)
    );

    assign imem_req_o   = req_q;
    assign imem_addr_o  = pc;
    assign ifid_pc_o    = payload.pc;
    assign ifid_pc4_o   = payload.pc4;
    assign ifid_instr_o = payload.instr;
    assign ifid_imm16_o = payload.instr[15:0];

`ifdef FETCH_PERF_CNT_EN
    // Count effective IF/ID loads and discarded (killed) responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_o <= '0;
            perf_discard_o <= '0;
        end else begin
            if (load_c && !flush_i) begin
                perf_fetched_o <= perf_fetched_o + 32'd1;
            end
            if (discard_c) begin
                perf_discard_o <= perf_discard_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboard bench for fetch_ifid_stage: expected IF/ID contents are queued
// when a response is driven and compared when IF/ID is expected to load.
module tb_fetch_ifid_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic [15:0] ifid_imm16_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_discard_o;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_ifid_stage #(
        .RESET_PC (32'h0000_0000),
        .INSTR_W  (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ready_i     (imem_ready_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .ifid_valid_o     (ifid_valid_o),
        .ifid_pc_o        (ifid_pc_o),
        .ifid_pc4_o       (ifid_pc4_o),
        .ifid_instr_o     (ifid_instr_o),
        .ifid_imm16_o     (ifid_imm16_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o   (perf_fetched_o),
        .perf_discard_o   (perf_discard_o)
`endif
    );

    // Stimulus helpers; every task starts and ends just after a falling edge
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept();
        imem_ready_i = 1'b1;
        @(negedge clk);
        imem_ready_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] pc, input logic [31:0] data, input bit expect_load);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        if (expect_load) exp_q.push_back({pc, data});
        @(negedge clk);
        imem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req_o, ifid_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ctrl got req/valid=%b required=00", {imem_req_o, ifid_valid_o});
        end
        checks++;
        if ({ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o} !== 112'd0) begin
            failures++;
            $display("FAIL reset_ifid got pc=%h pc4=%h instr=%h imm=%h required all zero",
                     ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        exp_t e;
        logic [112:0] got, want;
        wait_req(ok);
        checks++;
        if (!ok || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL first_req got ok=%0d addr=%h required 1 00000000", ok, imem_addr_o);
        end
        accept();
        checks++;
        if (imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL wait_req_low got %b required 0", imem_req_o);
        end
        respond(32'h0, 32'h2008_FFFF, 1'b1);
        e = exp_q.pop_front();
        got  = {ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o};
        want = {1'b1, e.pc, e.pc + 32'd4, e.instr, e.instr[15:0]};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL basic_ifid got %h required %h", got, want);
        end
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            failures++;
            $display("FAIL basic_next_addr got req=%b addr=%h required 1 00000004", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [112:0] got, want;
        accept();
        stall_i = 1'b1;
        respond(32'h4, 32'h8C01_0004, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_req_o !== 1'b0 || ifid_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got req=%b valid=%b required 0 0", i, imem_req_o, ifid_valid_o);
            end
            @(negedge clk);
        end
        stall_i = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        got  = {ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o};
        want = {1'b1, e.pc, e.pc + 32'd4, e.instr, e.instr[15:0]};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL stall_release_ifid got %h required %h", got, want);
        end
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
            failures++;
            $display("FAIL stall_next_addr got req=%b addr=%h required 1 00000008", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_redirect_wait();
        accept();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0100;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        @(negedge clk);
        respond(32'h8, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (ifid_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL redirect_wait_discard got valid=%b required 0", ifid_valid_o);
        end
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            failures++;
            $display("FAIL redirect_wait_addr got req=%b addr=%h required 1 00000100", imem_req_o, imem_addr_o);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_discard_o !== 32'd1 || perf_fetched_o !== 32'd2) begin
            failures++;
            $display("FAIL perf_after_redirect got discard=%0d fetched=%0d required 1 2", perf_discard_o, perf_fetched_o);
        end
`endif
    endtask

    task automatic test_redirect_req();
        imem_ready_i     = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0203;
        @(negedge clk);
        imem_ready_i     = 1'b0;
        redirect_valid_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL redirect_req_accepted got req=%b required 0", imem_req_o);
        end
        respond(32'h100, 32'h1111_2222, 1'b0);
        checks++;
        if (ifid_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            failures++;
            $display("FAIL redirect_req_kill got valid=%b req=%b addr=%h required 0 1 00000200",
                     ifid_valid_o, imem_req_o, imem_addr_o);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_discard_o !== 32'd2) begin
            failures++;
            $display("FAIL perf_discard_req got %0d required 2", perf_discard_o);
        end
`endif
    endtask

    task automatic test_flush_stall();
        exp_t e;
        logic [112:0] got, want;
        accept();
        respond(32'h200, 32'h2402_0005, 1'b1);
        e = exp_q.pop_front();
        got  = {ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o};
        want = {1'b1, e.pc, e.pc + 32'd4, e.instr, e.instr[15:0]};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL flush_setup_ifid got %h required %h", got, want);
        end
        stall_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ifid_valid_o !== 1'b1 || ifid_instr_o !== e.instr) begin
            failures++;
            $display("FAIL stall_holds_ifid got valid=%b instr=%h required 1 %h", ifid_valid_o, ifid_instr_o, e.instr);
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        stall_i = 1'b0;
        checks++;
        if (ifid_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_beats_stall got valid=%b required 0", ifid_valid_o);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [112:0] got, want;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_aligned_addr got req=%b addr=%h required 1 fffffffc", imem_req_o, imem_addr_o);
        end
        accept();
        respond(32'hFFFF_FFFC, 32'h3C01_ABCD, 1'b1);
        e = exp_q.pop_front();
        got  = {ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o};
        want = {1'b1, e.pc, e.pc + 32'd4, e.instr, e.instr[15:0]};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL wrap_ifid got %h required %h", got, want);
        end
        checks++;
        if (imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next_addr got %h required 00000000", imem_addr_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_t e;
        logic [112:0] got, want;
        logic [31:0] pc;
        logic [31:0] data;
        pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            wait_req(ok);
            checks++;
            if (!ok || imem_addr_o !== pc) begin
                failures++;
                $display("FAIL b2b_addr %0d got ok=%0d addr=%h required 1 %h", i, ok, imem_addr_o, pc);
            end
            accept();
            data = $urandom;
            respond(pc, data, 1'b1);
            e = exp_q.pop_front();
            got  = {ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o};
            want = {1'b1, e.pc, e.pc + 32'd4, e.instr, e.instr[15:0]};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL b2b_ifid %0d got %h required %h", i, got, want);
            end
            pc = pc + 32'd4;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [112:0] got, want;
        accept();
        rst_n         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0BAD_0BAD;
        @(negedge clk);
        checks++;
        if ({imem_req_o, ifid_valid_o} !== 2'b00 ||
            {ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o} !== 112'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got req=%b valid=%b pc=%h instr=%h required all zero",
                     imem_req_o, ifid_valid_o, ifid_pc_o, ifid_instr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid_i = 1'b0;
        checks++;
        if (ifid_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_stray got valid=%b req=%b addr=%h required 0 1 00000000",
                     ifid_valid_o, imem_req_o, imem_addr_o);
        end
        accept();
        respond(32'h0, 32'h1234_5678, 1'b1);
        e = exp_q.pop_front();
        got  = {ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_imm16_o};
        want = {1'b1, e.pc, e.pc + 32'd4, e.instr, e.instr[15:0]};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_mid_first_fetch got %h required %h", got, want);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched_o !== 32'd1 || perf_discard_o !== 32'd0) begin
            failures++;
            $display("FAIL perf_after_reset got fetched=%0d discard=%0d required 1 0", perf_fetched_o, perf_discard_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_flush_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d entries required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
